// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - multiplexed 7-segment scanner driving one shared external decoder
module seg_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              dec_bin,
    input  logic [7:0]              dec_seg,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]         SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                  state, state_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic                    show_en, show_en_nxt;
    logic [7:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic                    frame_end;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending;
    logic                    accept;

    assign load_ready = !pending;
    assign accept     = load_valid && !pending;
    assign dec_bin    = active[4*int'(idx) +: 4];

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        show_en_nxt = show_en;
        seg_nxt     = seg_out;
        an_nxt      = an_out;
        frame_end   = 1'b0;
        case (state)
            ST_BLANK: begin
                seg_nxt = '0;
                an_nxt  = '0;
                if (cnt == BLANK_LAST) begin
                    state_nxt   = ST_SHOW;
                    cnt_nxt     = '0;
                    show_en_nxt = digit_en[idx];
                    if (digit_en[idx]) begin
                        an_nxt  = AN_ONE << idx;
                        seg_nxt = dec_seg;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_SHOW: begin
                // Enable is latched at slot entry so a mid-slot digit_en change cannot flicker.
                seg_nxt = show_en ? dec_seg : 8'h00;
                if (cnt == SHOW_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    seg_nxt   = '0;
                    an_nxt    = '0;
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    frame_end = (idx == IDX_LAST);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            idx        <= '0;
            cnt        <= '0;
            show_en    <= 1'b0;
            seg_out    <= '0;
            an_out     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            show_en    <= show_en_nxt;
            seg_out    <= seg_nxt;
            an_out     <= an_nxt;
            frame_done <= frame_end;
        end
    end

    // Commit needs pending already set, accept needs it clear, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (accept) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end
        end
    end

endmodule
